// File: rtl/sevenseg_scan_pkg.sv
// Shared constants and types for the multiplexed four-digit seven-segment scanner.
package sevenseg_scan_pkg;

    localparam int unsigned NDIG  = 4;
    localparam int unsigned NIB_W = 4;
    localparam int unsigned SEG_W = 7;
    localparam int unsigned VAL_W = NDIG * NIB_W;

    localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;
    localparam logic [NDIG-1:0]  AN_OFF    = 4'hF;

    // Active-low {g,f,e,d,c,b,a} patterns for hex digits 0..F
    localparam logic [SEG_W-1:0] SEG_HEX [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    typedef struct packed {
        logic [NDIG-1:0]  en;
        logic [NDIG-1:0]  dp;
        logic [VAL_W-1:0] value;
    } disp_t;

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_ON    = 1'b1
    } state_t;

endpackage

// File: rtl/sevenseg_scan_if.sv
// Data/display bundle of the scanner; brightness exists only when SEVSEG_PWM_EN is defined.
interface sevenseg_scan_if;

    logic [15:0] value;
    logic [3:0]  dp_in;
    logic [3:0]  digit_en;
    logic        load;
`ifdef SEVSEG_PWM_EN
    logic [3:0]  brightness;
`endif
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic        frame;

`ifdef SEVSEG_PWM_EN
    modport master (output value, dp_in, digit_en, load, brightness,
                    input  seg, dp, an, frame);
    modport slave  (input  value, dp_in, digit_en, load, brightness,
                    output seg, dp, an, frame);
`else
    modport master (output value, dp_in, digit_en, load,
                    input  seg, dp, an, frame);
    modport slave  (input  value, dp_in, digit_en, load,
                    output seg, dp, an, frame);
`endif

endinterface

// File: rtl/sevenseg_hex_decode.sv
// Combinational hex nibble to active-low seven-segment pattern.
module sevenseg_hex_decode
    import sevenseg_scan_pkg::*;
(
    input  logic [NIB_W-1:0] hex,
    output logic [SEG_W-1:0] seg_c
);

    always_comb seg_c = SEG_HEX[hex];

endmodule

// File: rtl/sevenseg_scan.sv
// Four-digit seven-segment scanner with per-slot blanking and tear-free frame updates.
// Optional PWM dimming via brightness when SEVSEG_PWM_EN is defined.
module sevenseg_scan
    import sevenseg_scan_pkg::*;
#(
    parameter int unsigned PRESCALE_W = 16,
    parameter int unsigned BLANK_CYC  = 256
) (
    input logic            clk,
    input logic            rst,
    sevenseg_scan_if.slave bus
);

    localparam logic [PRESCALE_W-1:0] CNT_MAX   = '1;
    localparam logic [PRESCALE_W-1:0] BLANK_LIM = PRESCALE_W'(BLANK_CYC);
    localparam logic [1:0]            DIG_LAST  = 2'(NDIG - 1);

    logic [PRESCALE_W-1:0] cnt_q, cnt_d;
    logic [1:0]            d_q, d_d;
    state_t                state_q, state_d;
    disp_t                 pend_q, pend_d;
    disp_t                 disp_q, disp_d;
    logic [SEG_W-1:0]      seg_q, seg_d;
    logic                  dp_q, dp_d;
    logic [NDIG-1:0]       an_q, an_d;
    logic                  frame_q, frame_d;

    logic [NIB_W-1:0]      nib_c;
    logic [SEG_W-1:0]      dec_seg_c;
    logic                  pwm_ok_c;

    assign nib_c = disp_q.value[{d_q, 2'b00} +: NIB_W];

    sevenseg_hex_decode u_dec (
        .hex   (nib_c),
        .seg_c (dec_seg_c)
    );

`ifdef SEVSEG_PWM_EN
    assign pwm_ok_c = (cnt_q[3:0] <= bus.brightness);
`else
    assign pwm_ok_c = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            d_q     <= '0;
            state_q <= ST_BLANK;
            pend_q  <= '0;
            disp_q  <= '0;
            seg_q   <= SEG_BLANK;
            dp_q    <= 1'b1;
            an_q    <= AN_OFF;
            frame_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            d_q     <= d_d;
            state_q <= state_d;
            pend_q  <= pend_d;
            disp_q  <= disp_d;
            seg_q   <= seg_d;
            dp_q    <= dp_d;
            an_q    <= an_d;
            frame_q <= frame_d;
        end
    end

    always_comb begin
        cnt_d   = cnt_q + PRESCALE_W'(1);
        d_d     = d_q;
        pend_d  = pend_q;
        disp_d  = disp_q;
        frame_d = 1'b0;
        seg_d   = SEG_BLANK;
        dp_d    = 1'b1;
        an_d    = AN_OFF;

        // Display takes the pending copy as it stood before any same-cycle load
        if (cnt_q == CNT_MAX) begin
            d_d = d_q + 2'd1;
            if (d_q == DIG_LAST) begin
                disp_d  = pend_q;
                frame_d = 1'b1;
            end
        end

        if (bus.load) begin
            pend_d.en    = bus.digit_en;
            pend_d.dp    = bus.dp_in;
            pend_d.value = bus.value;
        end

        state_d = (cnt_d < BLANK_LIM) ? ST_BLANK : ST_ON;

        case (state_q)
            ST_ON: begin
                if (disp_q.en[d_q] && pwm_ok_c) begin
                    an_d  = ~(4'b0001 << d_q);
                    seg_d = dec_seg_c;
                    dp_d  = ~disp_q.dp[d_q];
                end
            end
            default: ;
        endcase
    end

    assign bus.seg   = seg_q;
    assign bus.dp    = dp_q;
    assign bus.an    = an_q;
    assign bus.frame = frame_q;

endmodule

// File: tb/tb_sevenseg_scan.sv
// Bench for sevenseg_scan (PRESCALE_W=6, BLANK_CYC=4): arithmetic reference model plus directed checks.
module tb_sevenseg_scan;

    localparam int SLOT  = 64;
    localparam int FRAME = 256;
    localparam int BLANK = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sevenseg_scan_if bus ();

    sevenseg_scan #(.PRESCALE_W(6), .BLANK_CYC(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [6:0] hex_tbl [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    bit chk_en = 1'b0;

    // Model: n = clock edges since reset; digit/slot position follows by division
    int          n;
    logic [15:0] m_pend_val, m_disp_val;
    logic [3:0]  m_pend_en, m_disp_en, m_pend_dp, m_disp_dp;
    logic [3:0]  exp_an;
    logic [6:0]  exp_seg;
    logic        exp_dp, exp_frame;
    logic [3:0]  bright;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            n = 0;
            m_pend_val = '0; m_pend_en = '0; m_pend_dp = '0;
            m_disp_val = '0; m_disp_en = '0; m_disp_dp = '0;
            exp_an = 4'hF; exp_seg = 7'h7F; exp_dp = 1'b1; exp_frame = 1'b0;
        end else begin
            int c, d;
            bit lit;
            c = n % SLOT;
            d = (n / SLOT) % 4;
            lit = (c >= BLANK) && m_disp_en[d];
`ifdef SEVSEG_PWM_EN
            lit = lit && ((c % 16) <= int'(bright));
`endif
            if (lit) begin
                exp_an  = 4'hF & ~(4'(1) << d);
                exp_seg = hex_tbl[4'((m_disp_val >> (4 * d)) & 16'hF)];
                exp_dp  = ~m_disp_dp[d];
            end else begin
                exp_an = 4'hF; exp_seg = 7'h7F; exp_dp = 1'b1;
            end
            n++;
            exp_frame = (n % FRAME == 0);
            if (n % FRAME == 0) begin
                m_disp_val = m_pend_val; m_disp_en = m_pend_en; m_disp_dp = m_pend_dp;
            end
            if (bus.load) begin
                m_pend_val = bus.value; m_pend_en = bus.digit_en; m_pend_dp = bus.dp_in;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_an",    32'(bus.an),    32'(exp_an));
            chk("model_seg",   32'(bus.seg),   32'(exp_seg));
            chk("model_dp",    32'(bus.dp),    32'(exp_dp));
            chk("model_frame", 32'(bus.frame), 32'(exp_frame));
        end
    end

    task automatic wait_frame(input string name, input int max_cyc);
        bit seen = 1'b0;
        for (int i = 0; i < max_cyc && !seen; i++) begin
            @(negedge clk);
            if (bus.frame) seen = 1'b1;
        end
        if (!seen) chk({name, "_timeout"}, 32'(0), 32'(1));
    endtask

    task automatic wait_an(input string name, input logic [3:0] an_v, input int max_cyc,
                           input logic [6:0] seg_v);
        bit seen = 1'b0;
        for (int i = 0; i < max_cyc && !seen; i++) begin
            @(negedge clk);
            if (bus.an == an_v) seen = 1'b1;
        end
        if (!seen) chk({name, "_timeout"}, 32'(0), 32'(1));
        else       chk(name, 32'(bus.seg), 32'(seg_v));
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] en, input logic [3:0] dpv);
        bus.value = v; bus.digit_en = en; bus.dp_in = dpv; bus.load = 1'b1;
        @(negedge clk);
        bus.load = 1'b0;
    endtask

    task automatic wait_pos(input int pos);
        bit hit = 1'b0;
        for (int i = 0; i < 2 * FRAME && !hit; i++) begin
            @(negedge clk);
            if (n % FRAME == pos) hit = 1'b1;
        end
        if (!hit) chk("wait_pos_timeout", 32'(0), 32'(1));
    endtask

    initial begin
        int t0, viol, dp_low, an_low;
        bus.value = '0; bus.digit_en = '0; bus.dp_in = '0; bus.load = 1'b0;
`ifdef SEVSEG_PWM_EN
        bus.brightness = 4'hF;
`endif
        bright = 4'hF;
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        chk("rst_an",    32'(bus.an),    32'h0000000F);
        chk("rst_seg",   32'(bus.seg),   32'h0000007F);
        chk("rst_dp",    32'(bus.dp),    32'h00000001);
        chk("rst_frame", 32'(bus.frame), 32'h00000000);
        rst = 1'b0;

        // Basic display of 1234 after the next boundary
        do_load(16'h1234, 4'hF, 4'h0);
        wait_frame("f1234", 300);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("slot_blank_an", 32'(bus.an), 32'h0000000F);
        end
        @(negedge clk);
        chk("slot_first_on_an", 32'(bus.an), 32'h0000000E);
        chk("digit0_is_4", 32'(bus.seg), 32'h00000019);
        wait_an("digit3_is_1", 4'b0111, 260, 7'b1111001);

        // Frame period
        wait_frame("fper_a", 300);
        t0 = cyc;
        wait_frame("fper_b", 300);
        chk("frame_period", 32'(cyc - t0), 32'(FRAME));

        // Last load in a frame wins
        do_load(16'hAAAA, 4'hF, 4'h0);
        repeat (10) @(negedge clk);
        do_load(16'hBEEF, 4'hF, 4'h0);
        wait_frame("fbeef", 300);
        wait_an("beef_d0_F", 4'b1110, 80, 7'b0001110);
        wait_an("beef_d3_b", 4'b0111, 260, 7'b0000011);

        // Load on the boundary edge itself lands one frame later
        wait_pos(FRAME - 1);
        do_load(16'hC0DE, 4'hF, 4'h0);
        chk("frame_after_bnd_load", 32'(bus.frame), 32'h00000001);
        wait_an("bnd_still_F", 4'b1110, 80, 7'b0001110);
        wait_frame("fc0de", 300);
        wait_an("c0de_d0_E", 4'b1110, 80, 7'b0000110);

        // Load during the frame-pulse cycle lands one frame later
        wait_frame("fpulse", 300);
        do_load(16'h5678, 4'hF, 4'h0);
        wait_an("pulse_still_E", 4'b1110, 80, 7'b0000110);
        wait_frame("f5678", 300);
        wait_an("5678_d0_8", 4'b1110, 80, 7'b0000000);

        // Sparse digit enable and single decimal point
        do_load(16'h3210, 4'b0101, 4'b0001);
        wait_frame("fsparse", 300);
        viol = 0; dp_low = 0;
        for (int i = 0; i < 2 * FRAME; i++) begin
            @(negedge clk);
            if (!bus.an[1] || !bus.an[3]) viol++;
            if (!bus.dp) begin
                dp_low++;
                if (bus.an != 4'b1110) viol++;
            end
        end
        chk("sparse_violations", 32'(viol), 32'(0));
        chk("sparse_dp_low_cycles", 32'(dp_low), 32'(2 * 60));

`ifdef SEVSEG_PWM_EN
        bus.brightness = 4'h3;
        bright = 4'h3;
        wait_frame("fpwm", 300);
        an_low = 0;
        for (int i = 0; i < FRAME; i++) begin
            @(negedge clk);
            if (bus.an != 4'hF) an_low++;
        end
        chk("pwm_an_low_cycles", 32'(an_low), 32'(2 * 12));
        bus.brightness = 4'hF;
        bright = 4'hF;
`else
        an_low = 0;
`endif

        // Reset mid-slot at cnt=30 of digit 2
        wait_pos(2 * SLOT + 30);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_an",    32'(bus.an),    32'h0000000F);
        chk("midrst_seg",   32'(bus.seg),   32'h0000007F);
        chk("midrst_frame", 32'(bus.frame), 32'h00000000);
        chk("midrst_d0",    32'(dut.d_q),   32'h00000000);
        rst = 1'b0;
        t0 = cyc;
        wait_frame("fmidrst", 300);
        chk("midrst_frame_gap", 32'(cyc - t0), 32'(FRAME));

        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/sevenseg_scan.md
SEVENSEG_SCAN -- requirements
Module: sevenseg_scan

Interface
REQ-001 SHALL have parameter PRESCALE_W, default 16, meaning width of the per-digit slot counter; slot length is 2^PRESCALE_W clk cycles.
REQ-002 SHALL have parameter BLANK_CYC, default 256, meaning dead-time cycles at the start of each slot, with legal range 1 to 2^PRESCALE_W-17.
REQ-003 SHALL have ports:
- clk  in  1  system clock; one clock only.
- rst  in  1  reset, synchronous, active-high.
- value  in  16  four hex nibbles; nibble k (value[4k+3:4k]) shows on digit k, digit 0 rightmost.
- dp_in  in  4  decimal point per digit, 1 = lit.
- digit_en  in  4  per-digit enable; 0 = digit dark.
- load  in  1  strobe that captures value, dp_in and digit_en into the pending register.
- brightness  in  4  duty level; present only with SEVSEG_PWM_EN.
- seg  out  7  active-low segments, bit order {g,f,e,d,c,b,a}.
- dp  out  1  active-low decimal point.
- an  out  4  active-low anodes.
- frame  out  1  one-cycle pulse at each frame boundary.

Function
REQ-004 SHALL run the prescaler cnt from 0 to 2^PRESCALE_W-1 and then wrap; each wrap advances digit index d as 0,1,2,3,0.
REQ-005 SHALL hold an=4'b1111, seg=7'h7F and dp=1 while cnt<BLANK_CYC (state BLANK); from cnt=BLANK_CYC to slot end the block SHALL be in state ON.
REQ-006 In ON, SHALL drive an[d]=0 (other anodes 1) only when the display digit_en[d]=1; otherwise all anodes SHALL stay 1.
REQ-007 SHALL register seg/dp/an outputs, so outputs lag the internal state by exactly one clk cycle.
REQ-008 SHALL use this hex decode: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
REQ-009 On load=1, SHALL copy value/dp_in/digit_en into the pending register; if several loads occur within one frame, the last one wins.
REQ-010 At a frame boundary (cnt wrap with d=3, so d becomes 0), SHALL copy pending into the display register and assert frame for exactly that cycle; the display SHALL never change mid-frame (no tearing).
REQ-011 If load coincides with the frame-boundary cycle, the new data SHALL go to pending only and SHALL be displayed at the following boundary.
REQ-012 Worst-case latency from load to display SHALL be 4*2^PRESCALE_W+1 cycles.

Reset
REQ-013 When rst=1 at a clk edge, SHALL set cnt=0, d=0, pending=0, display=0 (all digit_en 0), an=4'b1111, seg=7'h7F, dp=1 and frame=0.
REQ-014 Reset mid-slot SHALL take effect on the next clk edge, and scanning SHALL restart at digit 0 in BLANK.

Configuration
REQ-015 With SEVSEG_PWM_EN defined, the brightness port SHALL exist and the anode in ON SHALL be active only when cnt[3:0]<=brightness (brightness=F gives full on, 0 gives 1/16 duty); brightness SHALL be sampled live, not through the pending register.
REQ-016 Without SEVSEG_PWM_EN, the brightness port and its logic SHALL be absent and ON SHALL drive the enabled anode for the whole ON phase.

Structure
REQ-017 The shared package/include SHALL hold NDIG=4, SEG_BLANK=7'h7F, AN_OFF=4'hF and the hex segment constants.
REQ-018 The hex-to-segment lookup SHALL be a combinational sub-module, sevenseg_hex_decode (4-bit in, 7-bit active-low out), instantiated once on the current digit's nibble.

Verification (PRESCALE_W=6, BLANK_CYC=4)
REQ-019 Reset, then load value=16'h1234, digit_en=F, dp_in=0 -> after the next frame pulse, digit 0 (an=1110) SHALL show seg=0011001 ('4') and digit 3 (an=0111) SHALL show 1111001 ('1').
REQ-020 Check the slot boundaries -> an=1111 SHALL hold for cycles 0-3 of every slot and the active anode for cycles 4-63; the frame pulse SHALL recur every 256 cycles.
REQ-021 Load 16'hAAAA, then 16'hBEEF in the same frame -> the next frame SHALL show only BEEF, with no frame showing AAAA; a load on the frame-pulse cycle SHALL appear one frame later.
REQ-022 Set digit_en=4'b0101 and dp_in=4'b0001 -> an[1] and an[3] SHALL never go low, and dp=0 SHALL occur only while an=1110.
REQ-023 Assert rst at cnt=30 of digit 2 -> the next cycle SHALL give an=1111, seg=7F, d=0, and no frame pulse until 256 cycles later.
REQ-024 With SEVSEG_PWM_EN and brightness=3 -> within ON, the anode SHALL be low only when cnt[3:0]<=3 (4 of every 16 cycles).
